// File: rtl/i2c_bus_arbiter_if.sv
// Bundles the requester-side and controller-side handshake of the I2C bus arbiter.
// The slave modport is the arbiter itself. The master modport is its environment:
// the requesters and the i2c_controller.
interface i2c_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [24*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    req_done;
  logic [NUM_REQ-1:0]    req_err;
  logic [23:0]           i2c_data;
  logic                  i2c_start;
  logic                  i2c_done;
  logic                  i2c_ack;

  modport master (
    output req_valid, req_data, i2c_done, i2c_ack,
    input  grant, req_done, req_err, i2c_data, i2c_start
  );

  modport slave (
    input  req_valid, req_data, i2c_done, i2c_ack,
    output grant, req_done, req_err, i2c_data, i2c_start
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ requesters.
// Only one frame is in flight at a time. A NACKed frame is re-issued up to
// MAX_RETRY times before its owner receives req_done together with req_err.
module i2c_bus_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  i2c_bus_arbiter_if.slave        bus,
  output logic                    o_busy,
  output logic [7:0]              o_err_count
);
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StResp} state_e;

  state_e             r_state;
  logic [IdxW-1:0]    r_last_grant;
  logic [IdxW-1:0]    r_owner;
  logic [RetryW-1:0]  r_retry_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_err;
  logic [23:0]        r_data;
  logic               r_start;
  logic               r_busy;
  logic [7:0]         r_err_count;

  logic [IdxW-1:0]    w_sel;
  logic [IdxW-1:0]    w_cand;
  logic               w_sel_valid;
  int unsigned        w_idx;
  logic [23:0]        w_frames [NUM_REQ];

  // Unpack the flat request bus into one 24-bit frame per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_frames
    assign w_frames[g] = bus.req_data[24*g +: 24];
  end

  // Round-robin pick: first valid requester after last_grant, wrapping to 0
  always_comb begin
    w_sel       = '0;
    w_cand      = '0;
    w_sel_valid = 1'b0;
    w_idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = 32'(r_last_grant) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = IdxW'(w_idx);
      if (!w_sel_valid && bus.req_valid[w_cand]) begin
        w_sel_valid = 1'b1;
        w_sel       = w_cand;
      end
    end
  end

  // Frame sequencing FSM; every output is a register updated here
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_last_grant <= IdxW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_retry_cnt  <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_data       <= '0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_err_count  <= '0;
    end else begin
      // Strobes and completion pulses last a single cycle
      r_start <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_sel_valid) begin
            r_data      <= w_frames[w_sel];
            r_grant     <= NUM_REQ'(1) << w_sel;
            r_owner     <= w_sel;
            r_retry_cnt <= '0;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StIssue;
          end
        end
        StIssue: r_state <= StGuard;
        // One cycle where a done left over from the previous attempt is ignored
        StGuard: r_state <= StWait;
        StWait: begin
          if (bus.i2c_done) begin
            if (bus.i2c_ack) begin
              r_done  <= r_grant;
              r_state <= StResp;
            end else if (32'(r_retry_cnt) < MAX_RETRY) begin
              r_retry_cnt <= r_retry_cnt + RetryW'(1);
              r_start     <= 1'b1;
              r_state     <= StIssue;
            end else begin
              r_done  <= r_grant;
              r_err   <= r_grant;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
              r_state <= StResp;
            end
          end
        end
        StResp: begin
          r_last_grant <= r_owner;
          r_grant      <= '0;
          r_busy       <= 1'b0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.req_done  = r_done;
  assign bus.req_err   = r_err;
  assign bus.i2c_data  = r_data;
  assign bus.i2c_start = r_start;
  assign o_busy        = r_busy;
  assign o_err_count   = r_err_count;
endmodule
